// File: rtl/dist_mem_arbiter.sv
// dist_mem_arbiter
// Shares one single-port distance/predecessor memory among three requesters
// (0: Bellman-Ford sequencer, 1: path readback, 2: host debug). It makes at
// most one round-robin grant per cycle. A requester can lock the memory for
// multi-cycle bursts, and a watchdog forces the lock off after LOCK_MAX
// cycles. Read data returns to the issuing port through a tag pipeline.
//
// Ports
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_req/i_lock/i_we [2:0]     per-port request, lock, write enable
//   i_addr0..2, i_wdata0..2     per-port address and write data
//   o_gnt [2:0]                 one-hot grant (combinational)
//   o_rvalid [2:0], o_rdata     registered read return
//   o_mem_en/we/addr/wdata      memory strobe and muxed command
//   i_mem_rdata                 memory read data, RD_LAT cycles after strobe
//   o_busy                      locked, or a read is in flight
//   o_lock_timeout              sticky watchdog flag
module dist_mem_arbiter #(
   parameter int AW       = 13,
   parameter int DW       = 128,
   parameter int RD_LAT   = 1,
   parameter int LOCK_MAX = 64
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [2:0]    i_req,
   input  logic [2:0]    i_lock,
   input  logic [2:0]    i_we,
   input  logic [AW-1:0] i_addr0,
   input  logic [AW-1:0] i_addr1,
   input  logic [AW-1:0] i_addr2,
   input  logic [DW-1:0] i_wdata0,
   input  logic [DW-1:0] i_wdata1,
   input  logic [DW-1:0] i_wdata2,
   output logic [2:0]    o_gnt,
   output logic [2:0]    o_rvalid,
   output logic [DW-1:0] o_rdata,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_busy,
   output logic          o_lock_timeout
);

   localparam int LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t           r_state, w_state_n;
   logic [1:0]       r_ptr, w_ptr_n;
   logic [1:0]       r_own, w_own_n;
   logic [LCW-1:0]   r_lcnt, w_lcnt_n;
   logic [2:0]       r_mask, w_mask_n;
   logic             r_tout, w_tout_n;

   logic [1:0]       w_p1, w_p2, w_own_p1, w_idx_p1;
   logic [1:0]       w_idx;
   logic             w_any;
   logic             w_rd_issue;

   logic [RD_LAT-1:0] r_pv;
   logic [1:0]        r_pid [RD_LAT];
   logic [2:0]        r_rvalid;
   logic [DW-1:0]     r_rdata;

   // Arbitration: the owner alone while locked, else round-robin from r_ptr
   always_comb begin
      w_p1     = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
      w_p2     = (w_p1 == 2'd2) ? 2'd0 : w_p1 + 2'd1;
      w_own_p1 = (r_own == 2'd2) ? 2'd0 : r_own + 2'd1;
      w_any    = 1'b0;
      w_idx    = r_ptr;
      if (r_state == ST_LOCKED) begin
         w_idx = r_own;
         w_any = i_req[r_own];
      end else if (i_req[r_ptr]) begin
         w_idx = r_ptr;
         w_any = 1'b1;
      end else if (i_req[w_p1]) begin
         w_idx = w_p1;
         w_any = 1'b1;
      end else if (i_req[w_p2]) begin
         w_idx = w_p2;
         w_any = 1'b1;
      end
      w_idx_p1 = (w_idx == 2'd2) ? 2'd0 : w_idx + 2'd1;
   end

   always_comb begin
      o_gnt       = '0;
      o_mem_en    = w_any;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      if (w_any) begin
         o_gnt    = 3'(3'b001 << w_idx);
         o_mem_we = i_we[w_idx];
         case (w_idx)
            2'd0:    begin o_mem_addr = i_addr0; o_mem_wdata = i_wdata0; end
            2'd1:    begin o_mem_addr = i_addr1; o_mem_wdata = i_wdata1; end
            default: begin o_mem_addr = i_addr2; o_mem_wdata = i_wdata2; end
         endcase
      end
   end

   assign w_rd_issue = w_any & ~i_we[w_idx];

   // Next-state. A forced release takes priority over a simultaneous normal
   // release, so its mask set wins over the lock=0 clear for that cycle.
   always_comb begin
      w_state_n = r_state;
      w_ptr_n   = r_ptr;
      w_own_n   = r_own;
      w_lcnt_n  = r_lcnt;
      w_mask_n  = r_mask & i_lock;
      w_tout_n  = r_tout;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               if (i_lock[w_idx] && !r_mask[w_idx]) begin
                  w_state_n = ST_LOCKED;
                  w_own_n   = w_idx;
                  w_lcnt_n  = '0;
               end else begin
                  w_ptr_n = w_idx_p1;
               end
            end
         end
         default: begin
            w_lcnt_n = r_lcnt + 1'b1;
            if (r_lcnt == LCW'(LOCK_MAX - 1)) begin
               w_state_n       = ST_IDLE;
               w_ptr_n         = w_own_p1;
               w_tout_n        = 1'b1;
               w_mask_n[r_own] = 1'b1;
            end else if (!i_lock[r_own]) begin
               w_state_n = ST_IDLE;
               w_ptr_n   = w_own_p1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_own   <= '0;
         r_lcnt  <= '0;
         r_mask  <= '0;
         r_tout  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_ptr   <= w_ptr_n;
         r_own   <= w_own_n;
         r_lcnt  <= w_lcnt_n;
         r_mask  <= w_mask_n;
         r_tout  <= w_tout_n;
      end
   end

   // Read tag pipeline: stage RD_LAT-1 lines up with i_mem_rdata
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pv     <= '0;
         r_rvalid <= '0;
         r_rdata  <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) r_pid[i] <= '0;
      end else begin
         r_pv[0]  <= w_rd_issue;
         r_pid[0] <= w_idx;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            r_pv[i]  <= r_pv[i-1];
            r_pid[i] <= r_pid[i-1];
         end
         r_rvalid <= r_pv[RD_LAT-1] ? 3'(3'b001 << r_pid[RD_LAT-1]) : 3'b000;
         if (r_pv[RD_LAT-1]) r_rdata <= i_mem_rdata;
      end
   end

   assign o_rvalid       = r_rvalid;
   assign o_rdata        = r_rdata;
   assign o_busy         = (r_state == ST_LOCKED) | (|r_pv);
   assign o_lock_timeout = r_tout;

endmodule
